// File: rtl/gpu_mem_pkg.sv
// Shared types for the memory arbiter: per-channel state encoding and request kinds.
package gpu_mem_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE        = 3'd0,
    ARB_READ_WAIT   = 3'd1,
    ARB_WRITE_WAIT  = 3'd2,
    ARB_READ_RELAY  = 3'd3,
    ARB_WRITE_RELAY = 3'd4
  } arb_state_t;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

endpackage

// File: rtl/mem_arb_channel.sv
// One memory channel: request FSM, round-robin pointer and the registered mem_* side.
// Write states exist only when MEM_ARBITER_WRITE_EN is defined.
module mem_arb_channel
  import gpu_mem_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int IDX_BITS      = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_grant,
  input  logic [IDX_BITS-1:0]      i_grant_idx,
  input  logic                     i_grant_kind,
  input  logic [ADDR_BITS-1:0]     i_grant_addr,
  input  logic [DATA_BITS-1:0]     i_grant_data,
  input  logic [NUM_CONSUMERS-1:0] i_cons_read_valid,
  input  logic [NUM_CONSUMERS-1:0] i_cons_write_valid,
  input  logic                     i_mem_read_ready,
  input  logic                     i_mem_write_ready,
  output arb_state_t               o_state,
  output logic [IDX_BITS-1:0]      o_idx,
  output logic [IDX_BITS-1:0]      o_rr,
  output logic                     o_mem_read_valid,
  output logic [ADDR_BITS-1:0]     o_mem_read_address,
  output logic                     o_mem_write_valid,
  output logic [ADDR_BITS-1:0]     o_mem_write_address,
  output logic [DATA_BITS-1:0]     o_mem_write_data,
  output logic                     o_read_done,
  output logic                     o_write_done,
  output logic                     o_release
);

  arb_state_t           r_state;
  logic [IDX_BITS-1:0]  r_idx;
  logic [IDX_BITS-1:0]  r_rr;
  logic                 r_mem_read_valid;
  logic [ADDR_BITS-1:0] r_mem_read_address;

  assign o_state            = r_state;
  assign o_idx              = r_idx;
  assign o_rr               = r_rr;
  assign o_mem_read_valid   = r_mem_read_valid;
  assign o_mem_read_address = r_mem_read_address;
  assign o_read_done        = (r_state == ARB_READ_WAIT) && i_mem_read_ready;

`ifdef MEM_ARBITER_WRITE_EN
  logic                 r_mem_write_valid;
  logic [ADDR_BITS-1:0] r_mem_write_address;
  logic [DATA_BITS-1:0] r_mem_write_data;

  assign o_mem_write_valid   = r_mem_write_valid;
  assign o_mem_write_address = r_mem_write_address;
  assign o_mem_write_data    = r_mem_write_data;
  assign o_write_done        = (r_state == ARB_WRITE_WAIT) && i_mem_write_ready;
  assign o_release = ((r_state == ARB_READ_RELAY)  && !i_cons_read_valid[r_idx]) ||
                     ((r_state == ARB_WRITE_RELAY) && !i_cons_write_valid[r_idx]);
`else
  logic w_unused;
  assign w_unused = ^{i_grant_kind, i_grant_data, i_cons_write_valid, i_mem_write_ready};

  assign o_mem_write_valid   = 1'b0;
  assign o_mem_write_address = '0;
  assign o_mem_write_data    = '0;
  assign o_write_done        = 1'b0;
  assign o_release = (r_state == ARB_READ_RELAY) && !i_cons_read_valid[r_idx];
`endif

  // Wrap is an explicit compare so non-power-of-two consumer counts work.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state            <= ARB_IDLE;
      r_idx              <= '0;
      r_rr               <= '0;
      r_mem_read_valid   <= 1'b0;
      r_mem_read_address <= '0;
`ifdef MEM_ARBITER_WRITE_EN
      r_mem_write_valid   <= 1'b0;
      r_mem_write_address <= '0;
      r_mem_write_data    <= '0;
`endif
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (i_grant) begin
            r_idx <= i_grant_idx;
            r_rr  <= (i_grant_idx == IDX_BITS'(NUM_CONSUMERS - 1)) ? '0 : i_grant_idx + IDX_BITS'(1);
`ifdef MEM_ARBITER_WRITE_EN
            if (i_grant_kind == REQ_WRITE) begin
              r_mem_write_valid   <= 1'b1;
              r_mem_write_address <= i_grant_addr;
              r_mem_write_data    <= i_grant_data;
              r_state             <= ARB_WRITE_WAIT;
            end else
`endif
            begin
              r_mem_read_valid   <= 1'b1;
              r_mem_read_address <= i_grant_addr;
              r_state            <= ARB_READ_WAIT;
            end
          end
        end
        ARB_READ_WAIT: begin
          if (i_mem_read_ready) begin
            r_mem_read_valid <= 1'b0;
            r_state          <= ARB_READ_RELAY;
          end
        end
        ARB_READ_RELAY: begin
          if (!i_cons_read_valid[r_idx]) r_state <= ARB_IDLE;
        end
`ifdef MEM_ARBITER_WRITE_EN
        ARB_WRITE_WAIT: begin
          if (i_mem_write_ready) begin
            r_mem_write_valid <= 1'b0;
            r_state           <= ARB_WRITE_RELAY;
          end
        end
        ARB_WRITE_RELAY: begin
          if (!i_cons_write_valid[r_idx]) r_state <= ARB_IDLE;
        end
`endif
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares NUM_CHANNELS memory channels among NUM_CONSUMERS requesters; owns the serving mask,
// the ascending-channel claim chain and the consumer-side registers. Writes need MEM_ARBITER_WRITE_EN.
module mem_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

  localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  logic [NUM_CONSUMERS-1:0]                r_serving;
  logic [NUM_CONSUMERS-1:0]                r_cons_rd_ready;
  logic [NUM_CONSUMERS-1:0]                r_cons_wr_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] r_cons_rd_data;

  logic [NUM_CONSUMERS-1:0] w_wr_req;
  logic [NUM_CONSUMERS-1:0] w_taken;
  arb_state_t               w_ch_state   [NUM_CHANNELS];
  logic [IDX_BITS-1:0]      w_ch_rr      [NUM_CHANNELS];
  logic [IDX_BITS-1:0]      w_ch_idx     [NUM_CHANNELS];
  logic [IDX_BITS-1:0]      w_grant_idx  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]     w_grant_addr [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     w_grant_data [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  w_grant;
  logic [NUM_CHANNELS-1:0]  w_grant_kind;
  logic [NUM_CHANNELS-1:0]  w_rd_done;
  logic [NUM_CHANNELS-1:0]  w_wr_done;
  logic [NUM_CHANNELS-1:0]  w_release;

`ifdef MEM_ARBITER_WRITE_EN
  assign w_wr_req = consumer_write_valid;
`else
  assign w_wr_req = '0;
`endif

  // Channels claim in ascending index; w_taken accumulates so a consumer goes to one channel only.
  always_comb begin
    int                  w_cand;
    logic [IDX_BITS-1:0] w_cand_idx;
    w_cand       = 0;
    w_cand_idx   = '0;
    w_taken      = r_serving;
    w_grant      = '0;
    w_grant_kind = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      w_grant_idx[ch]  = '0;
      w_grant_addr[ch] = '0;
      w_grant_data[ch] = '0;
      if (w_ch_state[ch] == ARB_IDLE) begin
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
          w_cand = int'(w_ch_rr[ch]) + k;
          if (w_cand >= NUM_CONSUMERS) w_cand = w_cand - NUM_CONSUMERS;
          w_cand_idx = IDX_BITS'(w_cand);
          if (!w_grant[ch] && !w_taken[w_cand_idx] &&
              (consumer_read_valid[w_cand_idx] || w_wr_req[w_cand_idx])) begin
            w_grant[ch]         = 1'b1;
            w_taken[w_cand_idx] = 1'b1;
            w_grant_idx[ch]     = w_cand_idx;
            if (consumer_read_valid[w_cand_idx]) begin
              w_grant_kind[ch] = REQ_READ;
              w_grant_addr[ch] = consumer_read_address[w_cand_idx];
            end else begin
              w_grant_kind[ch] = REQ_WRITE;
              w_grant_addr[ch] = consumer_write_address[w_cand_idx];
              w_grant_data[ch] = consumer_write_data[w_cand_idx];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_serving       <= '0;
      r_cons_rd_ready <= '0;
      r_cons_wr_ready <= '0;
      r_cons_rd_data  <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        if (w_rd_done[ch]) begin
          r_cons_rd_ready[w_ch_idx[ch]] <= 1'b1;
          r_cons_rd_data[w_ch_idx[ch]]  <= mem_read_data[ch];
        end
        if (w_wr_done[ch]) r_cons_wr_ready[w_ch_idx[ch]] <= 1'b1;
        if (w_release[ch]) begin
          r_cons_rd_ready[w_ch_idx[ch]] <= 1'b0;
          r_cons_wr_ready[w_ch_idx[ch]] <= 1'b0;
          r_serving[w_ch_idx[ch]]       <= 1'b0;
        end
        if (w_grant[ch]) r_serving[w_grant_idx[ch]] <= 1'b1;
      end
    end
  end

  assign consumer_read_ready  = r_cons_rd_ready;
  assign consumer_read_data   = r_cons_rd_data;
  assign consumer_write_ready = r_cons_wr_ready;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    mem_arb_channel #(
      .ADDR_BITS    (ADDR_BITS),
      .DATA_BITS    (DATA_BITS),
      .NUM_CONSUMERS(NUM_CONSUMERS),
      .IDX_BITS     (IDX_BITS)
    ) u_ch (
      .clk                (clk),
      .reset              (reset),
      .i_grant            (w_grant[g]),
      .i_grant_idx        (w_grant_idx[g]),
      .i_grant_kind       (w_grant_kind[g]),
      .i_grant_addr       (w_grant_addr[g]),
      .i_grant_data       (w_grant_data[g]),
      .i_cons_read_valid  (consumer_read_valid),
      .i_cons_write_valid (consumer_write_valid),
      .i_mem_read_ready   (mem_read_ready[g]),
      .i_mem_write_ready  (mem_write_ready[g]),
      .o_state            (w_ch_state[g]),
      .o_idx              (w_ch_idx[g]),
      .o_rr               (w_ch_rr[g]),
      .o_mem_read_valid   (mem_read_valid[g]),
      .o_mem_read_address (mem_read_address[g]),
      .o_mem_write_valid  (mem_write_valid[g]),
      .o_mem_write_address(mem_write_address[g]),
      .o_mem_write_data   (mem_write_data[g]),
      .o_read_done        (w_rd_done[g]),
      .o_write_done       (w_wr_done[g]),
      .o_release          (w_release[g])
    );
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a 1-channel and a 2-channel instance, each with a latency-programmable memory model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]      c1_rv, c1_wv, c1_crr, c1_cwr;
  logic [3:0][7:0] c1_ra, c1_wa, c1_wd, c1_crd;
  logic [0:0]      m1_rv, m1_rr, m1_wv, m1_wr;
  logic [0:0][7:0] m1_ra, m1_rd, m1_wa, m1_wdat;

  logic [3:0]      c2_rv, c2_wv, c2_crr, c2_cwr;
  logic [3:0][7:0] c2_ra, c2_wa, c2_wd, c2_crd;
  logic [1:0]      m2_rv, m2_rr, m2_wv, m2_wr;
  logic [1:0][7:0] m2_ra, m2_rd, m2_wa, m2_wdat;

  mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(c1_rv), .consumer_read_address(c1_ra),
    .consumer_read_ready(c1_crr), .consumer_read_data(c1_crd),
    .consumer_write_valid(c1_wv), .consumer_write_address(c1_wa),
    .consumer_write_data(c1_wd), .consumer_write_ready(c1_cwr),
    .mem_read_valid(m1_rv), .mem_read_address(m1_ra),
    .mem_read_ready(m1_rr), .mem_read_data(m1_rd),
    .mem_write_valid(m1_wv), .mem_write_address(m1_wa),
    .mem_write_data(m1_wdat), .mem_write_ready(m1_wr)
  );

  mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(c2_rv), .consumer_read_address(c2_ra),
    .consumer_read_ready(c2_crr), .consumer_read_data(c2_crd),
    .consumer_write_valid(c2_wv), .consumer_write_address(c2_wa),
    .consumer_write_data(c2_wd), .consumer_write_ready(c2_cwr),
    .mem_read_valid(m2_rv), .mem_read_address(m2_ra),
    .mem_read_ready(m2_rr), .mem_read_data(m2_rd),
    .mem_write_valid(m2_wv), .mem_write_address(m2_wa),
    .mem_write_data(m2_wdat), .mem_write_ready(m2_wr)
  );

  // Memory model: data = address ^ 0xB5; ready pulses mem_lat cycles after valid rises.
  int mem_lat = 1;
  logic [2:0] w_mrv, w_mwv, w_mrr, w_mwr;
  assign w_mrv = {m2_rv, m1_rv};
  assign w_mwv = {m2_wv, m1_wv};
  assign m1_rr = w_mrr[0];
  assign m2_rr = w_mrr[2:1];
  assign m1_wr = w_mwr[0];
  assign m2_wr = w_mwr[2:1];
  assign m1_rd[0] = m1_ra[0] ^ 8'hB5;
  assign m2_rd[0] = m2_ra[0] ^ 8'hB5;
  assign m2_rd[1] = m2_ra[1] ^ 8'hB5;

  for (genvar g = 0; g < 3; g++) begin : g_mem
    logic rdy_r, rdy_w;
    int   cnt_r, cnt_w;
    assign w_mrr[g] = rdy_r;
    assign w_mwr[g] = rdy_w;
    always @(posedge clk) begin
      if (reset) begin
        rdy_r <= 1'b0; rdy_w <= 1'b0; cnt_r <= 0; cnt_w <= 0;
      end else begin
        if (w_mrv[g] && !rdy_r) begin
          if (cnt_r >= mem_lat - 1) begin rdy_r <= 1'b1; cnt_r <= 0; end
          else cnt_r <= cnt_r + 1;
        end else rdy_r <= 1'b0;
        if (w_mwv[g] && !rdy_w) begin
          if (cnt_w >= mem_lat - 1) begin rdy_w <= 1'b1; cnt_w <= 0; end
          else cnt_w <= cnt_w + 1;
        end else rdy_w <= 1'b0;
      end
    end
  end

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         dut2;
    logic [3:0] rv;
    logic [1:0] exp_mrv;
    logic [7:0] exp_a0;
    logic [7:0] exp_a1;
    logic [3:0] exp_crr;
    logic [1:0] dsel;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int got;
    int hi;
    int rdy_cyc;
    logic prev_mrv;
    logic [3:0] prev_crr;
    logic [7:0] a;

    // single read on dut1 (consumer 2 @0x10), then dual channel on dut2
    vecs[0]  = '{0, 4'b0100, 2'b01, 8'h10, 8'h00, 4'b0000, 2'd2, 8'h00};
    vecs[1]  = '{0, 4'b0100, 2'b01, 8'h10, 8'h00, 4'b0000, 2'd2, 8'h00};
    vecs[2]  = '{0, 4'b0100, 2'b00, 8'h10, 8'h00, 4'b0100, 2'd2, 8'hA5};
    vecs[3]  = '{0, 4'b0000, 2'b00, 8'h10, 8'h00, 4'b0000, 2'd2, 8'hA5};
    vecs[4]  = '{0, 4'b0000, 2'b00, 8'h10, 8'h00, 4'b0000, 2'd2, 8'hA5};
    vecs[5]  = '{1, 4'b0011, 2'b11, 8'h50, 8'h51, 4'b0000, 2'd0, 8'h00};
    vecs[6]  = '{1, 4'b0011, 2'b11, 8'h50, 8'h51, 4'b0000, 2'd0, 8'h00};
    vecs[7]  = '{1, 4'b0011, 2'b00, 8'h50, 8'h51, 4'b0011, 2'd0, 8'hE5};
    vecs[8]  = '{1, 4'b0000, 2'b00, 8'h50, 8'h51, 4'b0000, 2'd1, 8'hE4};
    vecs[9]  = '{1, 4'b1100, 2'b11, 8'h52, 8'h53, 4'b0000, 2'd1, 8'hE4};
    vecs[10] = '{1, 4'b1100, 2'b11, 8'h52, 8'h53, 4'b0000, 2'd2, 8'h00};
    vecs[11] = '{1, 4'b1100, 2'b00, 8'h52, 8'h53, 4'b1100, 2'd2, 8'hE7};
    vecs[12] = '{1, 4'b0000, 2'b00, 8'h52, 8'h53, 4'b0000, 2'd3, 8'hE6};

    reset = 1'b1;
    c1_rv = '0; c1_wv = '0; c1_ra = '0; c1_wa = '0; c1_wd = '0;
    c2_rv = '0; c2_wv = '0; c2_wa = '0; c2_wd = '0;
    c2_ra = {8'h53, 8'h52, 8'h51, 8'h50};
    c1_ra[2] = 8'h10;
    repeat (2) step();

    chk("rst_m1_rv", m1_rv, 0);
    chk("rst_m1_ra", m1_ra, 0);
    chk("rst_m1_wv", m1_wv, 0);
    chk("rst_c1_crr", c1_crr, 0);
    chk("rst_c1_crd", c1_crd, 0);
    chk("rst_m2_rv", m2_rv, 0);
    chk("rst_m2_ra", m2_ra, 0);
    chk("rst_c2_crr", c2_crr, 0);
    chk("rst_c2_cwr", c2_cwr, 0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].dut2) begin c2_rv = vecs[i].rv; c1_rv = '0; end
      else              begin c1_rv = vecs[i].rv; c2_rv = '0; end
      step();
      if (vecs[i].dut2) begin
        chk($sformatf("v%0d_mrv", i), m2_rv, vecs[i].exp_mrv);
        chk($sformatf("v%0d_a0", i), m2_ra[0], vecs[i].exp_a0);
        chk($sformatf("v%0d_a1", i), m2_ra[1], vecs[i].exp_a1);
        chk($sformatf("v%0d_crr", i), c2_crr, vecs[i].exp_crr);
        chk($sformatf("v%0d_crd", i), c2_crd[vecs[i].dsel], vecs[i].exp_d);
      end else begin
        chk($sformatf("v%0d_mrv", i), m1_rv, vecs[i].exp_mrv);
        chk($sformatf("v%0d_a0", i), m1_ra[0], vecs[i].exp_a0);
        chk($sformatf("v%0d_crr", i), c1_crr, vecs[i].exp_crr);
        chk($sformatf("v%0d_crd", i), c1_crd[vecs[i].dsel], vecs[i].exp_d);
      end
    end
    c2_rv = '0;

    // reset while dut1 waits on a slow read
    c1_ra = {8'h43, 8'h42, 8'h41, 8'h40};
    mem_lat = 3;
    c1_rv = 4'b0010;
    step();
    step();
    chk("midrst_pre_mrv", m1_rv, 1);
    chk("midrst_pre_addr", m1_ra, 8'h41);
    reset = 1'b1;
    c1_rv = '0;
    step();
    chk("midrst_mrv", m1_rv, 0);
    chk("midrst_ma", m1_ra, 0);
    chk("midrst_crr", c1_crr, 0);
    chk("midrst_crd", c1_crd, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("postrst_mrv", m1_rv, 0);
      chk("postrst_crr", c1_crr, 0);
    end
    mem_lat = 1;

    // round-robin with all four consumers requesting
    exp_q = {8'h40, 8'h41, 8'h42, 8'h43, 8'h40};
    got = 0;
    prev_mrv = 1'b0;
    prev_crr = '0;
    c1_rv = 4'b1111;
    for (int cyc = 0; cyc < 80 && got < 5; cyc++) begin
      step();
      if (m1_rv[0] && !prev_mrv) begin
        a = exp_q.pop_front();
        chk($sformatf("rr_grant%0d", got), m1_ra[0], a);
        got++;
      end
      for (int c = 0; c < 4; c++) begin
        if (c1_crr[c] && !prev_crr[c]) chk($sformatf("rr_data_c%0d", c), c1_crd[c], (8'h40 + 8'(c)) ^ 8'hB5);
      end
      prev_mrv = m1_rv[0];
      prev_crr = c1_crr;
      c1_rv = ~c1_crr;
    end
    chk("rr_grant_count", got, 5);
    c1_rv = '0;
    repeat (6) step();
    chk("rr_drain_mrv", m1_rv, 0);
    chk("rr_drain_crr", c1_crr, 0);

    // consumer 3 writes 0x7E to 0x22 with a two-cycle memory
    mem_lat = 2;
    c1_wa[3] = 8'h22;
    c1_wd[3] = 8'h7E;
    c1_wv = 4'b1000;
    hi = 0;
    rdy_cyc = -1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      step();
      if (m1_wv[0]) begin
        hi++;
        chk("wr_addr", m1_wa[0], 8'h22);
        chk("wr_data", m1_wdat[0], 8'h7E);
      end
      if (c1_cwr[3] && rdy_cyc < 0) rdy_cyc = cyc;
      if (c1_cwr[3]) c1_wv = '0;
    end
`ifdef MEM_ARBITER_WRITE_EN
    chk("wr_valid_cycles", hi, 3);
    chk("wr_ready_cycle", rdy_cyc, 4);
    chk("wr_ready_drop", c1_cwr, 0);
`else
    chk("wr_valid_cycles", hi, 0);
    chk("wr_ready_cycle", rdy_cyc, 32'hFFFF_FFFF);
    chk("wr_mem_addr", m1_wa, 0);
    chk("wr_mem_data", m1_wdat, 0);
    chk("wr_cons_ready", c1_cwr, 0);
`endif
    c1_wv = '0;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
